// File: rtl/tmds_encoder.sv
// tmds_encoder: DVI TMDS 8b/10b channel encoder with DC balancing, two-stage pipeline
module tmds_encoder #(
  parameter logic [7:0] ColorOn  = 8'hFF,
  parameter logic [7:0] ColorOff = 8'h00
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       ce_i,
  input  logic       de_i,
  input  logic       pix_i,
  input  logic [1:0] ctrl_i,
  output logic [9:0] tmds_o
);
  logic [7:0]        d;
  logic              de_q;
  logic [1:0]        ctrl_q;
  logic signed [4:0] cnt;
  logic [3:0]        n1d, n1q, n0q;
  logic              use_xnor, cond_a, cond_b;
  logic [8:0]        q_m;
  logic signed [4:0] diff, cnt_d;
  logic [9:0]        sym_d;

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      d      <= '0;
      de_q   <= 1'b0;
      ctrl_q <= '0;
    end else if (ce_i) begin
      d      <= pix_i ? ColorOn : ColorOff;
      de_q   <= de_i;
      ctrl_q <= ctrl_i;
    end

  always_comb begin
    n1d = '0;
    for (int i = 0; i < 8; i++) n1d = n1d + {3'b0, d[i]};
    use_xnor = n1d > 4'd4 || (n1d == 4'd4 && !d[0]);
    q_m[0] = d[0];
    for (int i = 1; i < 8; i++) q_m[i] = q_m[i-1] ^ d[i] ^ use_xnor;
    q_m[8] = !use_xnor;
    n1q = '0;
    for (int i = 0; i < 8; i++) n1q = n1q + {3'b0, q_m[i]};
    n0q = 4'd8 - n1q;
    diff = $signed({1'b0, n1q}) - $signed({1'b0, n0q});
    cond_a = cnt == 5'sd0 || n1q == n0q;
    cond_b = (cnt > 5'sd0 && n1q > n0q) || (cnt < 5'sd0 && n0q > n1q);
    sym_d = !de_q ? (ctrl_q == 2'd0 ? 10'h354 : ctrl_q == 2'd1 ? 10'h0AB :
                     ctrl_q == 2'd2 ? 10'h154 : 10'h2AB)
          : cond_a ? {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]}
          : cond_b ? {1'b1, q_m[8], ~q_m[7:0]}
          : {1'b0, q_m[8], q_m[7:0]};
    cnt_d = !de_q ? 5'sd0
          : cond_a ? cnt + (q_m[8] ? diff : -diff)
          : cond_b ? cnt + (q_m[8] ? 5'sd2 : 5'sd0) - diff
          : cnt - (q_m[8] ? 5'sd0 : 5'sd2) + diff;
  end

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      tmds_o <= 10'h354;
      cnt    <= 5'sd0;
    end else if (ce_i) begin
      tmds_o <= sym_d;
      cnt    <= cnt_d;
    end
endmodule

// File: tb/tb_tmds_encoder.sv
// tb_tmds_encoder: scoreboard bench for tmds_encoder with directed vectors and a reference encoder
module tb_tmds_encoder;
  logic       clk_i = 0, rst_ni = 0, ce_i = 0, de_i = 0, pix_i = 0, iss_in = 0;
  logic [1:0] ctrl_i = 0;
  logic [9:0] tmds_o;
  int         total = 0, bad = 0, mcnt = 0;

  typedef struct {
    logic [9:0] sym;
    int         cnt;
    logic       de;
    logic [7:0] val;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  always #5 clk_i = ~clk_i;

  tmds_encoder dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .ce_i  (ce_i),
    .de_i  (de_i),
    .pix_i (pix_i),
    .ctrl_i(ctrl_i),
    .tmds_o(tmds_o)
  );

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) need %0d (0x%0h) at %0t", name, act, act, req, req, $time);
    end
  endtask

  function automatic logic [8:0] decode(input logic [9:0] s);
    logic [7:0] x, v;
    case (s)
      10'h354: return {1'b1, 8'd0};
      10'h0AB: return {1'b1, 8'd1};
      10'h154: return {1'b1, 8'd2};
      10'h2AB: return {1'b1, 8'd3};
      default: begin
        x = s[9] ? ~s[7:0] : s[7:0];
        v[0] = x[0];
        for (int i = 1; i < 8; i++) v[i] = s[8] ? x[i] ^ x[i-1] : ~(x[i] ^ x[i-1]);
        return {1'b0, v};
      end
    endcase
  endfunction

  task automatic model(input logic de, input logic pix, input logic [1:0] c, output logic [9:0] s);
    logic [7:0] dd;
    logic [8:0] qm;
    int n1, ones, zeros;
    bit xn;
    if (!de) begin
      s = c == 0 ? 10'h354 : c == 1 ? 10'h0AB : c == 2 ? 10'h154 : 10'h2AB;
      mcnt = 0;
      return;
    end
    dd = pix ? 8'hFF : 8'h00;
    n1 = $countones(dd);
    xn = n1 > 4 || (n1 == 4 && dd[0] == 1'b0);
    qm[0] = dd[0];
    for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ dd[i]) : qm[i-1] ^ dd[i];
    qm[8] = !xn;
    ones = $countones(qm[7:0]);
    zeros = 8 - ones;
    if (mcnt == 0 || ones == zeros) begin
      s = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      mcnt += qm[8] ? ones - zeros : zeros - ones;
    end else if ((mcnt > 0 && ones > zeros) || (mcnt < 0 && zeros > ones)) begin
      s = {1'b1, qm[8], ~qm[7:0]};
      mcnt += 2 * int'(qm[8]) + zeros - ones;
    end else begin
      s = {1'b0, qm[8], qm[7:0]};
      mcnt += -2 * int'(!qm[8]) + ones - zeros;
    end
  endtask

  task automatic issue(input logic de, input logic pix, input logic [1:0] c, input logic [9:0] s, input int cn);
    @(negedge clk_i);
    ce_i = 1; de_i = de; pix_i = pix; ctrl_i = c; iss_in = 1;
    sb.push_back('{s, cn, de, de ? (pix ? 8'hFF : 8'h00) : {6'b0, c}});
  endtask

  task automatic idle(input logic ce);
    @(negedge clk_i);
    ce_i = ce; iss_in = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && sb.size() > 0; i++) idle(1);
    chk("drain_left", sb.size(), 0);
  endtask

  logic       p1 = 0, p2 = 0, have_last = 0;
  logic [9:0] last_exp = 0;
  always begin
    @(posedge clk_i);
    if (!rst_ni) begin
      p1 = 0; p2 = 0; have_last = 0;
    end else if (ce_i) begin
      p2 = p1; p1 = iss_in;
      #1;
      if (!p2) have_last = 0;
      else if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL underflow: got symbol 0x%0h need none", tmds_o);
      end else begin
        e = sb.pop_front();
        chk("sym", tmds_o, e.sym);
        chk("cnt", int'(dut.cnt), e.cnt);
        chk("decode", decode(tmds_o), {!e.de, e.val});
        last_exp = e.sym; have_last = 1;
      end
    end else begin
      #1;
      if (have_last) chk("frozen", tmds_o, last_exp);
    end
  end

  int exp3[9] = '{-8, 2, -6, 4, -4, 6, -2, 8, 0};
  logic [9:0] s;
  logic rde, rpix;
  logic [1:0] rc;

  initial begin
    repeat (6) begin
      @(negedge clk_i);
      chk("rst_sym", tmds_o, 10'h354);
      chk("rst_cnt", int'(dut.cnt), 0);
      ce_i = 1'($urandom); de_i = 1'($urandom); pix_i = 1'($urandom); ctrl_i = 2'($urandom);
    end
    @(negedge clk_i);
    rst_ni = 1; ce_i = 0; iss_in = 0;
    issue(0, 0, 0, 10'h354, 0);
    issue(0, 0, 1, 10'h0AB, 0);
    issue(0, 0, 2, 10'h154, 0);
    issue(0, 0, 3, 10'h2AB, 0);
    for (int i = 0; i < 9; i++) begin
      issue(1, 0, 0, i % 2 ? 10'h3FF : 10'h100, exp3[i]);
      if (i == 3) repeat (3) idle(0);
    end
    issue(0, 0, 0, 10'h354, 0);
    issue(1, 1, 0, 10'h200, -8);
    issue(0, 0, 1, 10'h0AB, 0);
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 9) == 0) idle(0);
      rde = (k % 60) >= 12;
      rpix = 1'($urandom);
      rc = 2'($urandom);
      model(rde, rpix, rc, s);
      issue(rde, rpix, rc, s, mcnt);
    end
    issue(0, 0, 0, 10'h354, 0);
    drain();
    issue(1, 1, 0, 10'h200, -8);
    issue(1, 0, 0, 10'h3FF, 2);
    drain();
    @(negedge clk_i);
    #2 rst_ni = 0;
    #1;
    chk("async_rst_sym", tmds_o, 10'h354);
    chk("async_rst_cnt", int'(dut.cnt), 0);
    @(negedge clk_i);
    rst_ni = 1; ce_i = 0; iss_in = 0;
    issue(1, 0, 0, 10'h100, -8);
    issue(1, 0, 0, 10'h3FF, 2);
    issue(0, 0, 2, 10'h154, 0);
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
